seed_random_top: RTL and testbench

- Random card dealer for the blackjack game.
- A free-running LFSR is the random source. Each rising edge on request_card_i deals one card from a 52-card deck, without replacement by default.
- The dealt card is held on card_to_send_o until the next deal. The block sits between the player/dealer control FSM and the hand-scoring logic.

---
 rtl/seed_random_top.sv | 179 +++++++++++++++++
 tb/tb_seed_random_top.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seed_random_top.sv
// Blackjack card dealer: free-running Galois LFSR picks a slot in a 52-card deck.
// Define SEED_RANDOM_REPLACE_EN to deal with replacement (no deck tracking, fixed 1-cycle latency).
module seed_random_top #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [15:0] LFSR_TAPS = 16'hB400
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       request_card_i,
  output logic [7:0] card_to_send_o
);

  // An all-zero Galois LFSR would lock up, so a zero seed is forced to one.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  function automatic logic [7:0] encode_card(input logic [5:0] idx);
    logic [1:0] suit;
    logic [5:0] rem;
    if (idx >= 6'd39) begin
      suit = 2'd3;
      rem  = idx - 6'd39;
    end else if (idx >= 6'd26) begin
      suit = 2'd2;
      rem  = idx - 6'd26;
    end else if (idx >= 6'd13) begin
      suit = 2'd1;
      rem  = idx - 6'd13;
    end else begin
      suit = 2'd0;
      rem  = idx;
    end
    return {suit, 2'b00, rem[3:0] + 4'd1};
  endfunction

  logic [15:0] lfsr_q, lfsr_d;
  logic        req_q, req_d;
  logic [7:0]  card_q, card_d;
  logic [5:0]  idx_q, idx_d;
  logic        req_edge;
  logic [5:0]  cap_idx;

  always_comb begin
    if (lfsr_q[0]) begin
      lfsr_d = (lfsr_q >> 1) ^ LFSR_TAPS;
    end else begin
      lfsr_d = lfsr_q >> 1;
    end
    req_d    = request_card_i;
    req_edge = request_card_i & ~req_q;
    if (lfsr_q[5:0] >= 6'd52) begin
      cap_idx = lfsr_q[5:0] - 6'd52;
    end else begin
      cap_idx = lfsr_q[5:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= SEED_EFF;
      req_q  <= 1'b0;
      card_q <= 8'h00;
      idx_q  <= 6'd0;
    end else begin
      lfsr_q <= lfsr_d;
      req_q  <= req_d;
      card_q <= card_d;
      idx_q  <= idx_d;
    end
  end

`ifdef SEED_RANDOM_REPLACE_EN
  logic pend_q, pend_d;

  always_comb begin
    pend_d = req_edge;
    if (req_edge) begin
      idx_d = cap_idx;
    end else begin
      idx_d = idx_q;
    end
    if (pend_q) begin
      card_d = encode_card(idx_q);
    end else begin
      card_d = card_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end
`else
  typedef enum logic {IDLE = 1'b0, SEARCH = 1'b1} state_t;
  state_t      state_q, state_d;
  logic [51:0] mask_q, mask_d;
  logic [5:0]  count_q, count_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_edge) begin
          state_d = SEARCH;
        end else begin
          state_d = IDLE;
        end
      end
      SEARCH: begin
        if (!mask_q[idx_q]) begin
          state_d = IDLE;
        end else begin
          state_d = SEARCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The deal that hands out the 52nd card also empties the deck for the next round.
  always_comb begin
    idx_d   = idx_q;
    mask_d  = mask_q;
    count_d = count_q;
    card_d  = card_q;
    case (state_q)
      IDLE: begin
        if (req_edge) begin
          idx_d = cap_idx;
        end else begin
          idx_d = idx_q;
        end
      end
      SEARCH: begin
        if (!mask_q[idx_q]) begin
          card_d = encode_card(idx_q);
          if (count_q == 6'd51) begin
            mask_d  = 52'd0;
            count_d = 6'd0;
          end else begin
            mask_d[idx_q] = 1'b1;
            count_d       = count_q + 6'd1;
          end
        end else if (idx_q == 6'd51) begin
          idx_d = 6'd0;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      default: begin
        idx_d = idx_q;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q  <= 52'd0;
      count_q <= 6'd0;
    end else begin
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end
`endif

  assign card_to_send_o = card_q;

endmodule

// File: tb/tb_seed_random_top.sv
// Randomized bench for seed_random_top: a deck-level reference model predicts every
// card and its deal latency; the output is compared every clock.
module tb_seed_random_top;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       request_card_i;
  logic [7:0] card_to_send_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  seed_random_top dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .request_card_i (request_card_i),
    .card_to_send_o (card_to_send_o)
  );

  // Reference model state: deck as a set of dealt indices, a pending deal and its countdown.
  logic [15:0] m_lfsr;
  bit          m_req_prev;
  bit          m_deck [52];
  int          m_used;
  bit          m_busy;
  int          m_remain;
  logic [7:0]  m_pend;
  logic [7:0]  m_out;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] card_of(input int i);
    logic [7:0] c;
    c = 8'(((i / 13) * 64) + (i % 13) + 1);
    return c;
  endfunction

  function automatic bit valid_card(input logic [7:0] c);
    return (c[5:4] == 2'b00) && (c[3:0] >= 4'd1) && (c[3:0] <= 4'd13);
  endfunction

  task automatic model_reset();
    m_lfsr     = 16'hACE1;
    m_req_prev = 1'b0;
    foreach (m_deck[i]) m_deck[i] = 1'b0;
    m_used   = 0;
    m_busy   = 1'b0;
    m_remain = 0;
    m_pend   = 8'h00;
    m_out    = 8'h00;
  endtask

  task automatic model_posedge(input bit req);
    int idx;
    int k;
    if (m_busy) begin
      m_remain--;
      if (m_remain == 0) begin
        m_out  = m_pend;
        m_busy = 1'b0;
      end
    end else if (req && !m_req_prev) begin
      idx = int'(m_lfsr) % 64;
      if (idx >= 52) idx -= 52;
`ifdef SEED_RANDOM_REPLACE_EN
      k = 1;
`else
      k = 1;
      while (m_deck[idx]) begin
        idx = (idx + 1) % 52;
        k++;
      end
      m_used++;
      if (m_used == 52) begin
        foreach (m_deck[i]) m_deck[i] = 1'b0;
        m_used = 0;
      end else begin
        m_deck[idx] = 1'b1;
      end
`endif
      m_pend   = card_of(idx);
      m_busy   = 1'b1;
      m_remain = k;
    end
    m_req_prev = req;
    if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
    else           m_lfsr = m_lfsr >> 1;
  endtask

  task automatic tick(input bit req);
    request_card_i = req;
    @(posedge clk_i);
    if (rst_i) model_reset();
    else       model_posedge(req);
    #1;
    check_eq("card", 32'(card_to_send_o), 32'(m_out));
  endtask

  task automatic pulse(input int hold, input int gap);
    repeat (hold) tick(1'b1);
    repeat (gap) tick(1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; output must clear before any clock edge.
  task automatic async_reset(input string tag);
    #3;
    rst_i = 1'b1;
    #1;
    check_eq(tag, 32'(card_to_send_o), 32'h00);
    model_reset();
    tick(1'b0);
    tick(1'b0);
    rst_i = 1'b0;
  endtask

  task automatic deck_round(input string tag, input int n_deals);
    bit seen [52];
    int n_seen;
    int ci;
    foreach (seen[i]) seen[i] = 1'b0;
    for (int d = 0; d < n_deals; d++) begin
      pulse($urandom_range(1, 5), 60);
      check_eq({tag, "_valid"}, 32'(valid_card(card_to_send_o)), 32'd1);
      ci = int'(card_to_send_o[7:6]) * 13 + int'(card_to_send_o[3:0]) - 1;
      if (ci >= 0 && ci < 52) seen[ci] = 1'b1;
    end
    n_seen = 0;
    foreach (seen[i]) n_seen += int'(seen[i]);
    check_eq({tag, "_distinct"}, 32'(n_seen), 32'(n_deals));
  endtask

  initial begin
    rst_i          = 1'b1;
    request_card_i = 1'b0;
    model_reset();
    #2;
    check_eq("reset_out", 32'(card_to_send_o), 32'h00);
    tick(1'b0);
    tick(1'b0);
    rst_i = 1'b0;
    repeat (10) tick(1'b0);
    check_eq("idle_out", 32'(card_to_send_o), 32'h00);

`ifdef SEED_RANDOM_REPLACE_EN
    for (int d = 0; d < 200; d++) begin
      pulse($urandom_range(1, 3), $urandom_range(1, 4));
      check_eq("rep_valid", 32'(valid_card(card_to_send_o)), 32'd1);
    end
    async_reset("rep_reset");
    pulse(2, 3);
    check_eq("rep_after_reset", 32'(valid_card(card_to_send_o)), 32'd1);
`else
    // Single request held for 100 ns.
    pulse(10, 50);
    check_eq("single_valid", 32'(valid_card(card_to_send_o)), 32'd1);

    // Second rising edge two clocks after the first, likely while still searching.
    for (int t = 0; t < 6; t++) begin
      tick(1'b1);
      tick(1'b0);
      pulse($urandom_range(1, 3), 60);
      check_eq("dbl_valid", 32'(valid_card(card_to_send_o)), 32'd1);
    end

    // Fresh deck: 52 distinct cards, then a reshuffled 53rd.
    async_reset("reset_full");
    repeat (3) tick(1'b0);
    deck_round("deck1", 52);
    pulse(2, 60);
    check_eq("deck53_valid", 32'(valid_card(card_to_send_o)), 32'd1);

    // Reset in the middle of a search, then a full distinct deck again.
    for (int t = 0; t < 30; t++) begin
      tick(1'b1);
      if (m_busy && m_remain > 1) break;
      pulse(1, 60);
    end
    async_reset("reset_mid");
    repeat (3) tick(1'b0);
    check_eq("after_mid_out", 32'(card_to_send_o), 32'h00);
    deck_round("deck2", 52);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
